fetch_prefetch_unit: RTL and testbench

//  Next-gen instruction fetch stage for the 5-stage core; replaces the single-cycle fetch stage.

---
 rtl/riscv_pkg.sv | 12 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/fetch_prefetch_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath width, reset vector and the fetch queue entry.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush; head is the oldest entry, read combinationally.
module sync_fifo #(
  parameter type T = logic [31:0],
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  input  logic          flush,
  output T              head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  T              mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // Explicit wrap keeps non-power-of-2 depths correct.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (32'(count) == DEPTH);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Prefetching instruction fetch stage: credit-limited sequential fetch into a queue, with redirect flush.
module fetch_prefetch_unit #(
  parameter int unsigned     XLEN            = riscv_pkg::XLEN,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = riscv_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            e_b_taken,
  input  logic [XLEN-1:0] e_alu_y,
  output logic            mem_i_req,
  output logic [XLEN-1:0] mem_i_ra,
  input  logic            mem_i_gnt,
  input  logic            mem_i_rvalid,
  input  logic [XLEN-1:0] mem_i_rd,
  output logic            f_valid,
  output logic [XLEN-1:0] f_instr,
  output logic [XLEN-1:0] f_pc,
  output logic [XLEN-1:0] f_pc4,
  input  logic            d_ready
);

  // XLEN must match riscv_pkg::XLEN since the queue entry type comes from the package.
  import riscv_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   outstanding_next;
  logic [OW-1:0]   discard;
  logic            started;
  logic            primed;
  logic            credit;
  logic            grant;
  logic            push;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic [CW-1:0]   q_count;
  logic            q_empty;
  logic            q_full;
  logic [XLEN-1:0] tag_pc;
  logic [OW-1:0]   tag_count;
  logic            tag_empty;
  logic            tag_full;
  logic            unused_align;

  assign unused_align = ^e_alu_y[1:0];

  // Credit counts in-flight requests against queue space, so every response has a slot.
  assign credit    = (32'(outstanding) + 32'(q_count) < DEPTH) &&
                     (32'(outstanding) < MAX_OUTSTANDING);
  assign mem_i_req = started && credit && !e_b_taken;
  assign mem_i_ra  = fetch_pc;
  assign grant     = mem_i_req && mem_i_gnt;

  assign pop        = f_valid && d_ready && !e_b_taken;
  assign push       = mem_i_rvalid && (discard == '0) && !e_b_taken;
  assign push_entry = '{pc: tag_pc, instr: mem_i_rd};

  always_comb begin
    outstanding_next = outstanding;
    if (grant && !mem_i_rvalid) begin
      outstanding_next = outstanding + OW'(1);
    end else if (!grant && mem_i_rvalid) begin
      outstanding_next = outstanding - OW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      started     <= 1'b0;
      primed      <= 1'b0;
    end else begin
      started     <= 1'b1;
      outstanding <= outstanding_next;
      if (push) begin
        primed <= 1'b1;
      end
      if (e_b_taken) begin
        fetch_pc <= {e_alu_y[XLEN-1:2], 2'b00};
        discard  <= outstanding_next;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (mem_i_rvalid && (discard != '0)) begin
          discard <= discard - OW'(1);
        end
      end
    end
  end

  sync_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (e_b_taken),
    .head      (head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  // Tags survive a redirect: discarded responses still retire their tag in order.
  sync_fifo #(
    .T     (logic [XLEN-1:0]),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tags (
    .clk       (clk),
    .reset     (reset),
    .push      (grant),
    .push_data (fetch_pc),
    .pop       (mem_i_rvalid),
    .flush     (1'b0),
    .head      (tag_pc),
    .count     (tag_count),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  assign f_valid = !q_empty;
  assign f_instr = head.instr;
  assign f_pc    = head.pc;
  assign f_pc4   = primed ? head.pc + XLEN'(4) : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (32'(outstanding) <= MAX_OUTSTANDING);
      assert (discard <= outstanding);
      assert (32'(q_count) + 32'(outstanding) <= DEPTH);
      assert (!(mem_i_rvalid && (outstanding == '0)));
      assert (!(mem_i_rvalid && tag_empty));
      assert (tag_count == outstanding);
      assert (!(grant && tag_full));
      assert (!(push && q_full && !pop));
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with an in-order, fixed-latency instruction memory.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        e_b_taken;
  logic [31:0] e_alu_y;
  logic        mem_i_req;
  logic [31:0] mem_i_ra;
  logic        mem_i_gnt;
  logic        mem_i_rvalid = 1'b0;
  logic [31:0] mem_i_rd = '0;
  logic        f_valid;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic [31:0] f_pc4;
  logic        d_ready;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned lat = 1;
  int unsigned mcyc = 0;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } resp_t;
  resp_t pend[$];

  fetch_prefetch_unit #(
    .XLEN            (32),
    .DEPTH           (4),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .e_b_taken    (e_b_taken),
    .e_alu_y      (e_alu_y),
    .mem_i_req    (mem_i_req),
    .mem_i_ra     (mem_i_ra),
    .mem_i_gnt    (mem_i_gnt),
    .mem_i_rvalid (mem_i_rvalid),
    .mem_i_rd     (mem_i_rd),
    .f_valid      (f_valid),
    .f_instr      (f_instr),
    .f_pc         (f_pc),
    .f_pc4        (f_pc4),
    .d_ready      (d_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Handshakes are final by the falling edge; responses are presented just after the rising edge.
  always @(negedge clk) begin
    if (reset) begin
      pend.delete();
    end else begin
      if (mem_i_rvalid && pend.size() > 0) void'(pend.pop_front());
      if (mem_i_req && mem_i_gnt) pend.push_back('{addr: mem_i_ra, due: mcyc + lat});
    end
  end

  always @(posedge clk) begin
    mcyc = mcyc + 1;
    #1;
    if (pend.size() > 0 && pend[0].due <= mcyc) begin
      mem_i_rvalid = 1'b1;
      mem_i_rd     = instr_of(pend[0].addr);
    end else begin
      mem_i_rvalid = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic negs(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_after(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after the edge that starts cycle C0 (first cycle out of reset).
  task automatic restart(input int unsigned l, input logic dr);
    drive_after(1);
    reset     = 1'b1;
    lat       = l;
    e_b_taken = 1'b0;
    e_alu_y   = '0;
    mem_i_gnt = 1'b1;
    d_ready   = dr;
    drive_after(2);
    reset = 1'b0;
  endtask

  initial begin
    e_b_taken = 1'b0;
    e_alu_y   = '0;
    mem_i_gnt = 1'b1;
    d_ready   = 1'b1;

    // Reset state
    negs(2);
    chk("rst_req",    32'(mem_i_req), 32'd0);
    chk("rst_fvalid", 32'(f_valid),   32'd0);
    chk("rst_ra",     mem_i_ra,       32'h0);
    chk("rst_instr",  f_instr,        32'h0);
    chk("rst_pc",     f_pc,           32'h0);
    chk("rst_pc4",    f_pc4,          32'h0);

    // 1: streaming, 1-cycle latency
    restart(1, 1'b1);
    negs(1);
    chk("t1_req_c0", 32'(mem_i_req), 32'd0);
    negs(1);
    chk("t1_req_c1", 32'(mem_i_req), 32'd1);
    chk("t1_ra_c1",  mem_i_ra,       32'h0);
    negs(1);
    chk("t1_fvalid_c2", 32'(f_valid), 32'd0);
    negs(1);
    chk("t1_fvalid_c3", 32'(f_valid), 32'd1);
    chk("t1_pc_c3",     f_pc,         32'h0);
    chk("t1_instr_c3",  f_instr,      instr_of(32'h0));
    chk("t1_ra_c3",     mem_i_ra,     32'h8);
    negs(1);
    chk("t1_pc_c4",  f_pc,     32'h4);
    chk("t1_pc4_c4", f_pc4,    32'h8);
    chk("t1_ra_c4",  mem_i_ra, 32'hC);
    negs(1);
    chk("t1_pc_c5", f_pc, 32'h8);
    negs(1);
    chk("t1_pc_c6",  f_pc,  32'hC);
    chk("t1_pc4_c6", f_pc4, 32'h10);

    // 2: consumer stalled, queue fills to DEPTH
    restart(1, 1'b0);
    negs(11);
    chk("t2_req_full",    32'(mem_i_req), 32'd0);
    chk("t2_fvalid_full", 32'(f_valid),   32'd1);
    chk("t2_pc_full",     f_pc,           32'h0);
    chk("t2_ra_full",     mem_i_ra,       32'h10);
    drive_after(1);
    d_ready = 1'b1;
    negs(1);
    chk("t2_pc_c11",  f_pc,           32'h0);
    chk("t2_req_c11", 32'(mem_i_req), 32'd0);
    negs(1);
    chk("t2_pc_c12",  f_pc,           32'h4);
    chk("t2_req_c12", 32'(mem_i_req), 32'd1);
    chk("t2_ra_c12",  mem_i_ra,       32'h10);
    negs(1);
    chk("t2_pc_c13", f_pc, 32'h8);
    negs(1);
    chk("t2_pc_c14", f_pc, 32'hC);
    negs(1);
    chk("t2_pc_c15", f_pc, 32'h10);

    // 3: grant withheld at 0x10
    restart(1, 1'b1);
    drive_after(5);
    mem_i_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      negs(1);
      chk("t3_req_hold", 32'(mem_i_req), 32'd1);
      chk("t3_ra_hold",  mem_i_ra,       32'h10);
    end
    drive_after(1);
    mem_i_gnt = 1'b1;
    negs(1);
    chk("t3_ra_c8", mem_i_ra, 32'h10);
    negs(1);
    chk("t3_ra_c9",     mem_i_ra,     32'h14);
    chk("t3_fvalid_c9", 32'(f_valid), 32'd0);
    negs(1);
    chk("t3_fvalid_c10", 32'(f_valid), 32'd1);
    chk("t3_pc_c10",     f_pc,         32'h10);

    // 4: redirect with two responses in flight, latency 3
    restart(3, 1'b1);
    negs(3);
    chk("t4_req_c2", 32'(mem_i_req), 32'd1);
    chk("t4_ra_c2",  mem_i_ra,       32'h4);
    drive_after(1);
    e_b_taken = 1'b1;
    e_alu_y   = 32'h203;
    negs(1);
    chk("t4_req_redir", 32'(mem_i_req), 32'd0);
    drive_after(1);
    e_b_taken = 1'b0;
    e_alu_y   = '0;
    negs(1);
    chk("t4_ra_c4",     mem_i_ra,       32'h200);
    chk("t4_req_c4",    32'(mem_i_req), 32'd0);
    chk("t4_fvalid_c4", 32'(f_valid),   32'd0);
    negs(1);
    chk("t4_req_c5", 32'(mem_i_req), 32'd1);
    chk("t4_ra_c5",  mem_i_ra,       32'h200);
    negs(1);
    chk("t4_fvalid_c6", 32'(f_valid), 32'd0);
    negs(2);
    chk("t4_fvalid_c8", 32'(f_valid), 32'd0);
    negs(1);
    chk("t4_fvalid_c9", 32'(f_valid), 32'd1);
    chk("t4_pc_c9",     f_pc,         32'h200);
    chk("t4_pc4_c9",    f_pc4,        32'h204);
    chk("t4_instr_c9",  f_instr,      instr_of(32'h200));

    // 5: redirect coinciding with rvalid and pop
    restart(1, 1'b1);
    negs(3);
    chk("t5_ra_c2", mem_i_ra, 32'h4);
    drive_after(1);
    e_b_taken = 1'b1;
    e_alu_y   = 32'h102;
    negs(1);
    chk("t5_fvalid_c3", 32'(f_valid),   32'd1);
    chk("t5_pc_c3",     f_pc,           32'h0);
    chk("t5_req_c3",    32'(mem_i_req), 32'd0);
    drive_after(1);
    e_b_taken = 1'b0;
    e_alu_y   = '0;
    negs(1);
    chk("t5_fvalid_c4", 32'(f_valid),   32'd0);
    chk("t5_req_c4",    32'(mem_i_req), 32'd1);
    chk("t5_ra_c4",     mem_i_ra,       32'h100);
    negs(1);
    chk("t5_fvalid_c5", 32'(f_valid), 32'd0);
    negs(1);
    chk("t5_fvalid_c6", 32'(f_valid), 32'd1);
    chk("t5_pc_c6",     f_pc,         32'h100);
    chk("t5_instr_c6",  f_instr,      instr_of(32'h100));

    // 6: reset with two requests outstanding and data queued
    restart(2, 1'b0);
    negs(6);
    chk("t6_fvalid_c5", 32'(f_valid), 32'd1);
    chk("t6_pc4_c5",    f_pc4,        32'h4);
    chk("t6_instr_c5",  f_instr,      instr_of(32'h0));
    drive_after(1);
    reset = 1'b1;
    negs(1);
    chk("t6_rst_req",    32'(mem_i_req), 32'd0);
    chk("t6_rst_fvalid", 32'(f_valid),   32'd0);
    chk("t6_rst_ra",     mem_i_ra,       32'h0);
    chk("t6_rst_pc",     f_pc,           32'h0);
    chk("t6_rst_instr",  f_instr,        32'h0);
    chk("t6_rst_pc4",    f_pc4,          32'h0);
    drive_after(2);
    reset   = 1'b0;
    lat     = 1;
    d_ready = 1'b1;
    negs(2);
    chk("t6_req_c1", 32'(mem_i_req), 32'd1);
    chk("t6_ra_c1",  mem_i_ra,       32'h0);
    negs(2);
    chk("t6_fvalid_c3", 32'(f_valid), 32'd1);
    chk("t6_pc_c3",     f_pc,         32'h0);
    chk("t6_instr_c3",  f_instr,      instr_of(32'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
